// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding and the
// 16-bit Fibonacci LFSR polynomial x^16+x^14+x^13+x^11+1.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } bounce_state_t;

  localparam int          LFSR_W    = 16;
  // Tap mask over bits 15,13,12,10 of a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR with a synchronous load that takes priority over
// the shift.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= SEED;
    else if (load) q <= load_val;
    else           q <= lfsr_next(q);
  end

endmodule

// File: rtl/bounce_generator.sv
// Emulates a bouncing mechanical switch: each level change on clean_in is
// replayed as an odd number of randomly spaced flips followed by a quiet period.
module bounce_generator
  import bounce_gen_pkg::*;
#(
  parameter int          BOUNCE_MAX = 7,
  parameter int          GAP_W      = 6,
  parameter int          SETTLE_CYC = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clean_in,
  input  logic        bounce_en,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        noisy_out,
  output logic        busy,
  output logic        bounce_done
);

  localparam int             REM_W       = 5;
  localparam int             SET_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0]     K_MAX       = 4'(BOUNCE_MAX);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

  bounce_state_t     state;
  logic              target;
  logic [REM_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap;
  logic [SET_W-1:0]  settle_cnt;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_load_val;
  logic [3:0]        k_pick;
  logic [GAP_W-1:0]  gap_raw;
  logic [GAP_W-1:0]  gap_pick;
  logic              lfsr_unused;

  // A zero seed would lock the LFSR, so it falls back to the reset seed
  assign lfsr_load_val = (seed == 16'h0000) ? SEED : seed;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  assign k_pick      = (lfsr_q[3:0] > K_MAX) ? K_MAX : lfsr_q[3:0];
  assign gap_raw     = lfsr_q[GAP_W+3:4];
  assign gap_pick    = (gap_raw == '0) ? GAP_W'(1) : gap_raw;
  assign lfsr_unused = ^lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      noisy_out   <= 1'b0;
      busy        <= 1'b0;
      bounce_done <= 1'b0;
      target      <= 1'b0;
      remaining   <= '0;
      gap         <= '0;
      settle_cnt  <= '0;
    end else begin
      bounce_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bounce_en) begin
            noisy_out <= clean_in;
          end else if (clean_in != noisy_out) begin
            // 2k+1 flips always lands the output on the new level
            state     <= BOUNCE;
            busy      <= 1'b1;
            target    <= clean_in;
            remaining <= REM_W'({k_pick, 1'b1});
            gap       <= gap_pick;
          end
        end
        BOUNCE: begin
          if (gap == GAP_W'(1)) begin
            noisy_out <= ~noisy_out;
            remaining <= remaining - REM_W'(1);
            gap       <= gap_pick;
            if (remaining == REM_W'(1)) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end else begin
            gap <= gap - GAP_W'(1);
          end
        end
        SETTLE: begin
          noisy_out <= target;
          if (settle_cnt == SET_W'(1)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bounce_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Randomized scoreboard bench: three bounce_generator configurations share one
// stimulus stream; a spec-level model predicts each bounce episode.
module tb_bounce_generator;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          SETTLE    = 16;
  localparam int          NCFG      = 3;
  localparam int          DEB_TIMER = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        clean_in;
  logic        bounce_en;
  logic        seed_load;
  logic [15:0] seed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int flips;
    int busy_cycles;
    bit level;
  } episode_t;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: new bit is the XOR of stages 16,14,13,11
  function automatic logic [15:0] refStep(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int BMAX = (g == 1) ? 0 : 7;
    localparam int GW   = (g == 2) ? 4 : 6;

    logic noisy, busy, done;

    bounce_generator #(
      .BOUNCE_MAX (BMAX),
      .GAP_W      (GW),
      .SETTLE_CYC (SETTLE),
      .SEED       (SEED)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .clean_in    (clean_in),
      .bounce_en   (bounce_en),
      .seed_load   (seed_load),
      .seed        (seed),
      .noisy_out   (noisy),
      .busy        (busy),
      .bounce_done (done)
    );

    logic [15:0] m_lfsr = SEED;
    bit          m_level = 1'b0;
    bit          m_idle = 1'b1;
    int          m_cycle = 0;
    int          m_free_at = 0;
    episode_t    exp_q[$];
    int          mon_flips = 0;
    int          mon_busy = 0;
    bit          mon_prev = 1'b0;

    // Whole episode from the LFSR value seen when the edge is accepted
    function automatic episode_t planEpisode(input logic [15:0] start, input bit lvl);
      episode_t    e;
      logic [15:0] v;
      int          k, gp;
      v = start;
      k = int'(start[3:0]);
      if (k > BMAX) k = BMAX;
      e.flips       = 2 * k + 1;
      e.level       = lvl;
      e.busy_cycles = SETTLE;
      for (int i = 0; i < e.flips; i++) begin
        gp = int'(v[GW+3:4]);
        if (gp == 0) gp = 1;
        e.busy_cycles += gp;
        for (int s = 0; s < gp; s++) v = refStep(v);
      end
      return e;
    endfunction

    always @(posedge clk) begin : p_model
      episode_t e;
      if (reset) begin
        m_lfsr    = SEED;
        m_level   = 1'b0;
        m_idle    = 1'b1;
        m_cycle   = 0;
        m_free_at = 0;
      end else begin
        if (m_cycle >= m_free_at) begin
          if (!bounce_en) begin
            m_level = clean_in;
          end else if (clean_in != m_level) begin
            e = planEpisode(m_lfsr, clean_in);
            exp_q.push_back(e);
            m_level   = clean_in;
            m_free_at = m_cycle + e.busy_cycles + 1;
          end
        end
        m_idle = (m_cycle >= m_free_at - 1);
        m_lfsr = seed_load ? ((seed == 16'h0000) ? SEED : seed) : refStep(m_lfsr);
        m_cycle++;
      end
    end

    always @(negedge clk) begin : p_monitor
      episode_t e;
      if (reset) begin
        exp_q.delete();
        mon_flips = 0;
        mon_busy  = 0;
        mon_prev  = 1'b0;
        checkOutput($sformatf("cfg%0d reset noisy_out", g), int'(noisy), 0);
        checkOutput($sformatf("cfg%0d reset busy", g), int'(busy), 0);
        checkOutput($sformatf("cfg%0d reset bounce_done", g), int'(done), 0);
        checkOutput($sformatf("cfg%0d reset lfsr", g), int'(dut.u_lfsr.q), int'(SEED));
      end else begin
        if (busy) begin
          mon_busy++;
          if (noisy != mon_prev) mon_flips++;
        end
        mon_prev = noisy;
        if (done) begin
          if (exp_q.size() == 0) begin
            checkOutput($sformatf("cfg%0d unexpected bounce_done", g), 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput($sformatf("cfg%0d flip count", g), mon_flips, e.flips);
            checkOutput($sformatf("cfg%0d busy cycles", g), mon_busy, e.busy_cycles);
            checkOutput($sformatf("cfg%0d final level", g), int'(noisy), int'(e.level));
          end
          mon_flips = 0;
          mon_busy  = 0;
        end
        checkOutput($sformatf("cfg%0d busy", g), int'(busy), int'(!m_idle));
        if (m_idle)
          checkOutput($sformatf("cfg%0d idle noisy_out", g), int'(noisy), int'(m_level));
      end
    end
  end

  // Downstream debouncer: follows its input after DEB_TIMER stable samples
  bit deb_out = 1'b0;
  bit deb_last = 1'b0;
  int deb_cnt = 0;
  int deb_edges = 0;

  always @(negedge clk) begin
    if (reset) begin
      deb_out  = 1'b0;
      deb_last = 1'b0;
      deb_cnt  = 0;
    end else begin
      if (g_cfg[2].noisy != deb_last) begin
        deb_cnt = 0;
      end else if (deb_out != deb_last) begin
        deb_cnt++;
        if (deb_cnt >= DEB_TIMER) begin
          deb_out = deb_last;
          deb_edges++;
          deb_cnt = 0;
        end
      end
      deb_last = g_cfg[2].noisy;
    end
  end

  task automatic applyStimulus(input bit c, input bit b, input bit sl, input logic [15:0] sd);
    clean_in  = c;
    bounce_en = b;
    seed_load = sl;
    seed      = sd;
    @(posedge clk);
    #2;
  endtask

  task automatic waitAllIdle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(g_cfg[0].m_idle && g_cfg[1].m_idle && g_cfg[2].m_idle) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!(g_cfg[0].m_idle && g_cfg[1].m_idle && g_cfg[2].m_idle))
      checkOutput({tag, " idle timeout"}, 0, 1);
  endtask

  initial begin : p_stimulus
    bit          c, b, sl, hit;
    logic [15:0] sd;
    int          deb_start;

    reset     = 1'b1;
    clean_in  = 1'b1;
    bounce_en = 1'b1;
    seed_load = 1'b0;
    seed      = 16'h0000;
    repeat (4) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("episode on first clock after reset", int'(g_cfg[0].busy), 1);
    waitAllIdle(5000, "post-reset episode");

    // Pass-through: output follows clean_in one cycle later, no episodes
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pass-through rising edge", int'(g_cfg[0].noisy), 1);
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0000);
    repeat (5) applyStimulus(clean_in, 1'b1, 1'b0, 16'h0000);

    // Seed 0x0001 then a rising edge
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    waitAllIdle(5000, "seeded episode");
    checkOutput("seeded final noisy_out", int'(g_cfg[0].noisy), 1);

    // Random traffic, including input changes while busy
    for (int i = 0; i < 2000; i++) begin
      c  = clean_in;
      sl = 1'b0;
      sd = 16'h0000;
      if ($urandom_range(0, 19) == 0) c = ~c;
      b = ($urandom_range(0, 4) != 0);
      if (g_cfg[0].m_idle && g_cfg[1].m_idle && g_cfg[2].m_idle && $urandom_range(0, 9) == 0) begin
        sl = 1'b1;
        b  = 1'b0;
        sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end
      applyStimulus(c, b, sl, sd);
    end
    waitAllIdle(5000, "random traffic");

    // Reset during the third gap of a bounce episode
    hit = 1'b0;
    for (int a = 0; a < 20 && !hit; a++) begin
      waitAllIdle(5000, "pre-reset");
      applyStimulus(~g_cfg[0].m_level, 1'b1, 1'b0, 16'h0000);
      for (int n = 0; n < 2000 && !hit && !g_cfg[0].m_idle; n++) begin
        if (g_cfg[0].mon_flips == 2) hit = 1'b1;
        else applyStimulus(clean_in, 1'b1, 1'b0, 16'h0000);
      end
    end
    checkOutput("reached third gap", int'(hit), 1);
    clean_in = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("noisy_out after mid-bounce reset", int'(g_cfg[0].noisy), 0);
    checkOutput("busy after mid-bounce reset", int'(g_cfg[0].busy), 0);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("idle after mid-bounce reset", int'(g_cfg[0].busy), 0);

    // Debouncer sees exactly one edge per clean edge
    repeat (30) applyStimulus(clean_in, 1'b1, 1'b0, 16'h0000);
    deb_start = deb_edges;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(~clean_in, 1'b1, 1'b0, 16'h0000);
      waitAllIdle(5000, "debounce episode");
      repeat ($urandom_range(30, 60)) applyStimulus(clean_in, 1'b1, 1'b0, 16'h0000);
    end
    checkOutput("debounced edge count", deb_edges - deb_start, 50);
    checkOutput("debounced level", int'(deb_out), int'(clean_in));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #900_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
